// File: rtl/lynx_noc_pkg.sv
// lynx_noc_pkg: shared flit layout, sizing helper and flit struct
// for the NoC injection path.
package lynx_noc_pkg;

    localparam int N_DEF           = 16;
    localparam int NUM_VC_DEF      = 2;
    localparam int N_ADDR_W_DEF    = $clog2(N_DEF);
    localparam int VC_ADDR_W_DEF   = $clog2(NUM_VC_DEF);
    localparam int FLIT_DATA_W_DEF = 16;

    localparam int PAYLOAD_LSB = 0;
    localparam int VC_LSB      = PAYLOAD_LSB + FLIT_DATA_W_DEF;
    localparam int DEST_LSB    = VC_LSB + VC_ADDR_W_DEF;
    localparam int TAIL_BIT    = DEST_LSB + N_ADDR_W_DEF;
    localparam int HEAD_BIT    = TAIL_BIT + 1;
    localparam int VALID_BIT   = HEAD_BIT + 1;
    localparam int FLIT_W_DEF  = VALID_BIT + 1;

    typedef struct packed {
        logic                       valid;
        logic                       head;
        logic                       tail;
        logic [N_ADDR_W_DEF-1:0]    dest;
        logic [VC_ADDR_W_DEF-1:0]   vc;
        logic [FLIT_DATA_W_DEF-1:0] payload;
    } flit_t;

    function automatic int num_flits(input int data_w, input int flit_w);
        return (data_w + flit_w - 1) / flit_w;
    endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// vc_credit_counter: credits available in one router input VC buffer.
// overflow flags a return that would exceed the buffer depth.
module vc_credit_counter #(
    parameter int  BUFFER_DEPTH = 4,
    localparam int CW           = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic has_credit,
    output logic overflow
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          full;

    assign full       = (cnt_q == CW'(BUFFER_DEPTH));
    assign has_credit = (cnt_q != '0);
    assign overflow   = inc && !dec && full;

    // A return and a send in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !full) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && has_credit) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= CW'(BUFFER_DEPTH);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/via_packetizer.sv
// via_packetizer: splits one accepted message into head/body/tail flits
// for a router injection port under per-VC credit flow control.
module via_packetizer
    import lynx_noc_pkg::*;
#(
    parameter int  N               = 16,
    parameter int  NUM_VC          = 2,
    parameter int  N_ADDR_WIDTH    = $clog2(N),
    parameter int  VC_ADDR_WIDTH   = $clog2(NUM_VC),
    parameter int  DATA_WIDTH      = 32,
    parameter int  FLIT_DATA_WIDTH = 16,
    parameter int  BUFFER_DEPTH    = 4,
    localparam int NUM_FLITS       = num_flits(DATA_WIDTH, FLIT_DATA_WIDTH),
    localparam int FLIT_WIDTH      = 3 + N_ADDR_WIDTH + VC_ADDR_WIDTH + FLIT_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [N_ADDR_WIDTH-1:0]  dest_in,
    input  logic [VC_ADDR_WIDTH-1:0] vc_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic [FLIT_WIDTH-1:0]    flit_out,
    input  logic [NUM_VC-1:0]        credit_in,
    output logic [31:0]              sent_count,
    output logic                     credit_err
);

    localparam int PAD_W = NUM_FLITS * FLIT_DATA_WIDTH;
    localparam int IDX_W = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FLITS - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                   state_q, state_d;
    logic [PAD_W-1:0]         data_q, data_d;
    logic [N_ADDR_WIDTH-1:0]  dest_q, dest_d;
    logic [VC_ADDR_WIDTH-1:0] vc_q, vc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [FLIT_WIDTH-1:0]    flit_q, flit_d;
    logic [31:0]              sent_q, sent_d;
    logic                     err_q, err_d;

    logic [NUM_VC-1:0] has_credit;
    logic [NUM_VC-1:0] overflow;
    logic              emit;

    assign emit = (state_q == SEND) && has_credit[vc_q];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_credit_counter #(
            .BUFFER_DEPTH(BUFFER_DEPTH)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (credit_in[v]),
            .dec       (emit && (vc_q == VC_ADDR_WIDTH'(v))),
            .has_credit(has_credit[v]),
            .overflow  (overflow[v])
        );
    end

    // Held low while reset is asserted so no message is taken mid-reset.
    assign ready_out  = rst && (state_q == IDLE);
    assign flit_out   = flit_q;
    assign sent_count = sent_q;
    assign credit_err = err_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dest_d  = dest_q;
        vc_d    = vc_q;
        idx_d   = idx_q;
        sent_d  = sent_q;
        flit_d  = '0;
        err_d   = err_q | (|overflow);
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    // Left-justify so a short last flit is zero-padded low.
                    data_d  = PAD_W'(data_in) << (PAD_W - DATA_WIDTH);
                    dest_d  = dest_in;
                    vc_d    = vc_in;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (emit) begin
                    flit_d = {1'b1, idx_q == '0, idx_q == LAST,
                              dest_q, vc_q,
                              data_q[PAD_W-1 -: FLIT_DATA_WIDTH]};
                    data_d = data_q << FLIT_DATA_WIDTH;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        sent_d  = sent_q + 32'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            dest_q  <= '0;
            vc_q    <= '0;
            idx_q   <= '0;
            flit_q  <= '0;
            sent_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            vc_q    <= vc_d;
            idx_q   <= idx_d;
            flit_q  <= flit_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
        end
    end

    always @(posedge clk) begin
        if (rst && valid_in && ready_out) begin
            assert (32'(vc_in) < NUM_VC);
        end
    end

endmodule
